// File: rtl/vmba_gen2_hub.sv
// VMBA gen2 device hub: command routing, round-robin read-back, clock enables and device resets.
// Optional ack timeout with sticky error flags is built when VMBA_TIMEOUT_EN is defined.
module vmba_gen2_hub #(
  parameter int DW      = 8,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int DIVW    = 4,
  parameter int RSTLEN  = 4,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_wr_valid,
  output logic              cpu_wr_ready,
  input  logic [SELW-1:0]   cpu_wr_sel,
  input  logic [DW-1:0]     cpu_wr_data,
  input  logic              cfg_wr,
  input  logic [SELW-1:0]   cfg_sel,
  input  logic [DIVW-1:0]   cfg_div,
  input  logic              cfg_rst,
  output logic [NCH*DW-1:0] dev_cmd,
  output logic [NCH-1:0]    dev_cmd_valid,
  input  logic [NCH-1:0]    dev_cmd_ack,
  input  logic [NCH*DW-1:0] dev_rd_data,
  input  logic [NCH-1:0]    dev_rd_valid,
  output logic [NCH-1:0]    dev_rd_ready,
  output logic [DW-1:0]     bus_out,
  output logic [SELW-1:0]   bus_out_src,
  output logic              bus_out_valid,
  input  logic              bus_out_ready,
  output logic [NCH-1:0]    clk_en,
  output logic [NCH-1:0]    dev_rst_n,
  output logic [NCH-1:0]    err_tmo
);

  localparam int RCW = $clog2(RSTLEN + 1);

  if (SELW != $clog2(NCH) || RSTLEN < 1 || TMO_CYC < 1) begin : g_bad_param
    $error("vmba_gen2_hub: inconsistent parameters");
  end

  typedef enum logic {S_EMPTY, S_FULL} rd_state_e;

  logic [RCW-1:0]  rcnt_q [NCH];
  logic [DW-1:0]   cmd_q  [NCH];
  logic [DIVW-1:0] div_q  [NCH];
  logic [DIVW-1:0] dcnt_q [NCH];
  logic [DW-1:0]   rd_word [NCH];
  logic [NCH-1:0]  in_rst, rst_hit, wr_hit, cfg_hit, tmo_hit, rd_req;
  logic [SELW-1:0] gnt_idx, ptr_q;
  logic            found, capture;
  int              cand;
  rd_state_e       state_q, state_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign dev_cmd[g*DW +: DW] = cmd_q[g];
    assign rd_word[g]          = dev_rd_data[g*DW +: DW];
  end

  // A cfg_rst to the addressed channel blocks the write in the same cycle
  assign cpu_wr_ready = ~dev_cmd_valid[cpu_wr_sel] & ~(cfg_rst & (cfg_sel == cpu_wr_sel));
  assign dev_rst_n    = ~in_rst;

  always_comb begin
    in_rst  = '0;
    rst_hit = '0;
    wr_hit  = '0;
    cfg_hit = '0;
    clk_en  = '0;
    for (int i = 0; i < NCH; i++) begin
      in_rst[i]  = (rcnt_q[i] != '0);
      rst_hit[i] = cfg_rst & (cfg_sel == SELW'(i));
      cfg_hit[i] = cfg_wr & (cfg_sel == SELW'(i));
      wr_hit[i]  = cpu_wr_valid & cpu_wr_ready & (cpu_wr_sel == SELW'(i));
      clk_en[i]  = ~in_rst[i] & (dcnt_q[i] == div_q[i]);
    end
  end

  // Device reset stretchers; async reset loads the full pulse length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) rcnt_q[i] <= RCW'(RSTLEN);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rst_hit[i])     rcnt_q[i] <= RCW'(RSTLEN);
        else if (in_rst[i]) rcnt_q[i] <= rcnt_q[i] - 1'b1;
      end
    end
  end

  // Command registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dev_cmd_valid <= '0;
      for (int i = 0; i < NCH; i++) cmd_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rst_hit[i]) begin
          dev_cmd_valid[i] <= 1'b0;
        end else if (wr_hit[i]) begin
          cmd_q[i]         <= cpu_wr_data;
          dev_cmd_valid[i] <= 1'b1;
        end else if (dev_cmd_valid[i] && dev_cmd_ack[i] && !in_rst[i]) begin
          dev_cmd_valid[i] <= 1'b0;
        end else if (tmo_hit[i]) begin
          dev_cmd_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef VMBA_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0]  tcnt_q [NCH];
  logic [NCH-1:0] err_q;

  always_comb begin
    tmo_hit = '0;
    for (int i = 0; i < NCH; i++)
      tmo_hit[i] = dev_cmd_valid[i] & (tcnt_q[i] == TW'(TMO_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
      for (int i = 0; i < NCH; i++) tcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rst_hit[i] || wr_hit[i] || tmo_hit[i] || !dev_cmd_valid[i]) tcnt_q[i] <= '0;
        else                                                            tcnt_q[i] <= tcnt_q[i] + 1'b1;
        if (rst_hit[i])      err_q[i] <= 1'b0;
        else if (tmo_hit[i]) err_q[i] <= 1'b1;
      end
    end
  end

  assign err_tmo = err_q;
`else
  assign tmo_hit = '0;
  assign err_tmo = '0;
`endif

  // Clock-enable dividers; the counter is held at zero while the device is in reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        div_q[i]  <= '0;
        dcnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_hit[i]) div_q[i] <= cfg_div;
        if (rst_hit[i] || in_rst[i] || cfg_hit[i] || clk_en[i]) dcnt_q[i] <= '0;
        else                                                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
      end
    end
  end

  // Round-robin search starting at the pointer, wrapping past NCH-1
  always_comb begin
    rd_req  = dev_rd_valid & ~in_rst & ~rst_hit;
    found   = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NCH) cand = cand - NCH;
      if (!found && rd_req[cand]) begin
        found   = 1'b1;
        gnt_idx = SELW'(cand);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    dev_rd_ready = '0;
    unique case (state_q)
      S_EMPTY: if (found) begin
        capture               = 1'b1;
        dev_rd_ready[gnt_idx] = 1'b1;
        state_d               = S_FULL;
      end
      S_FULL:  if (bus_out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  assign bus_out_valid = (state_q == S_FULL);

  // Read-back output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_EMPTY;
      ptr_q       <= '0;
      bus_out     <= '0;
      bus_out_src <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        bus_out     <= rd_word[gnt_idx];
        bus_out_src <= gnt_idx;
        ptr_q       <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vmba_gen2_hub.sv
// Randomised bench for vmba_gen2_hub against a per-channel behavioural model.
module tb_vmba_gen2_hub;

  localparam int DW = 8, NCH = 4, SELW = 2, DIVW = 4, RSTLEN = 4, TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_wr_valid, cpu_wr_ready;
  logic [SELW-1:0]   cpu_wr_sel;
  logic [DW-1:0]     cpu_wr_data;
  logic              cfg_wr, cfg_rst;
  logic [SELW-1:0]   cfg_sel;
  logic [DIVW-1:0]   cfg_div;
  logic [NCH*DW-1:0] dev_cmd, dev_rd_data;
  logic [NCH-1:0]    dev_cmd_valid, dev_cmd_ack, dev_rd_valid, dev_rd_ready;
  logic [DW-1:0]     bus_out;
  logic [SELW-1:0]   bus_out_src;
  logic              bus_out_valid, bus_out_ready;
  logic [NCH-1:0]    clk_en, dev_rst_n, err_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit            m_valid [NCH];
  logic [DW-1:0] m_cmd   [NCH];
  int            m_rleft [NCH];
  int            m_div   [NCH];
  int            m_age   [NCH];
  int            m_wait  [NCH];
  bit            m_err   [NCH];
  bit            m_full;
  logic [DW-1:0] m_bus;
  int            m_src, m_ptr;

  vmba_gen2_hub #(.DW(DW), .NCH(NCH), .SELW(SELW), .DIVW(DIVW), .RSTLEN(RSTLEN), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_sel(cpu_wr_sel), .cpu_wr_data(cpu_wr_data),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_rst(cfg_rst),
    .dev_cmd(dev_cmd), .dev_cmd_valid(dev_cmd_valid), .dev_cmd_ack(dev_cmd_ack),
    .dev_rd_data(dev_rd_data), .dev_rd_valid(dev_rd_valid), .dev_rd_ready(dev_rd_ready),
    .bus_out(bus_out), .bus_out_src(bus_out_src), .bus_out_valid(bus_out_valid), .bus_out_ready(bus_out_ready),
    .clk_en(clk_en), .dev_rst_n(dev_rst_n), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_valid[i] = 1'b0; m_cmd[i] = '0; m_rleft[i] = RSTLEN;
      m_div[i] = 0; m_age[i] = 0; m_wait[i] = 0; m_err[i] = 1'b0;
    end
    m_full = 1'b0; m_bus = '0; m_src = 0; m_ptr = 0;
  endtask

  function automatic bit exp_ready();
    return !m_valid[cpu_wr_sel] && !(cfg_rst && cfg_sel == cpu_wr_sel);
  endfunction

  // channel to be granted this cycle, or -1
  function automatic int pick();
    if (m_full) return -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (dev_rd_valid[c] && m_rleft[c] == 0 && !(cfg_rst && cfg_sel == c)) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int g);
    bit acc, hit, inr, tmo, cw;
    acc = cpu_wr_valid && exp_ready();
    for (int i = 0; i < NCH; i++) begin
      hit = cfg_rst && cfg_sel == i;
      cw  = cfg_wr && cfg_sel == i;
      inr = m_rleft[i] > 0;
      tmo = 1'b0;
`ifdef VMBA_TIMEOUT_EN
      tmo = m_valid[i] && (m_wait[i] == TMO - 1);
      if (hit) m_err[i] = 1'b0;
      else if (tmo) m_err[i] = 1'b1;
`endif
      if (hit) m_valid[i] = 1'b0;
      else if (acc && cpu_wr_sel == i) begin
        m_valid[i] = 1'b1; m_cmd[i] = cpu_wr_data; m_wait[i] = 0;
      end
      else if (m_valid[i] && dev_cmd_ack[i] && !inr) m_valid[i] = 1'b0;
      else if (tmo) m_valid[i] = 1'b0;
      else if (m_valid[i]) m_wait[i]++;
      if (cw) m_div[i] = int'(cfg_div);
      if (hit || inr || cw) m_age[i] = 0;
      else m_age[i]++;
      if (hit) m_rleft[i] = RSTLEN;
      else if (inr) m_rleft[i]--;
    end
    if (g >= 0) begin
      m_bus = dev_rd_data[g*DW +: DW]; m_src = g; m_ptr = (g + 1) % NCH; m_full = 1'b1;
    end else if (m_full && bus_out_ready) begin
      m_full = 1'b0;
    end
  endtask

  // one clock: compare at negedge+1, advance model at posedge
  task automatic cyc();
    logic [NCH*DW-1:0] e_cmd;
    logic [NCH-1:0]    e_v, e_en, e_rn, e_err, e_rdy;
    int g;
    if (!rst) model_reset();
    #1;
    g = pick();
    e_rdy = (g >= 0) ? (NCH'(1) << g) : '0;
    for (int i = 0; i < NCH; i++) begin
      e_cmd[i*DW +: DW] = m_cmd[i];
      e_v[i]   = m_valid[i];
      e_rn[i]  = (m_rleft[i] == 0);
      e_en[i]  = (m_rleft[i] == 0) && ((m_age[i] % (m_div[i] + 1)) == m_div[i]);
      e_err[i] = m_err[i];
    end
    check_eq("cpu_wr_ready", 64'(cpu_wr_ready), 64'(exp_ready()));
    check_eq("dev_cmd", 64'(dev_cmd), 64'(e_cmd));
    check_eq("dev_cmd_valid", 64'(dev_cmd_valid), 64'(e_v));
    check_eq("dev_rd_ready", 64'(dev_rd_ready), 64'(e_rdy));
    check_eq("bus_out_valid", 64'(bus_out_valid), 64'(m_full));
    check_eq("bus_out", 64'(bus_out), 64'(m_bus));
    check_eq("bus_out_src", 64'(bus_out_src), 64'(m_src));
    check_eq("clk_en", 64'(clk_en), 64'(e_en));
    check_eq("dev_rst_n", 64'(dev_rst_n), 64'(e_rn));
    check_eq("err_tmo", 64'(err_tmo), 64'(e_err));
    @(posedge clk);
    if (rst) model_update(g);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_wr_valid = 0; cpu_wr_sel = '0; cpu_wr_data = '0;
    cfg_wr = 0; cfg_sel = '0; cfg_div = '0; cfg_rst = 0;
    dev_cmd_ack = '0; dev_rd_data = '0; dev_rd_valid = '0; bus_out_ready = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    cyc(); cyc();
    // reset release: device resets stretched, everything else quiet
    rst = 1'b1;
    repeat (6) cyc();
    // write to ch2, stall a second write, then ack frees it
    cpu_wr_valid = 1; cpu_wr_sel = 2; cpu_wr_data = 8'hA5; cyc();
    cpu_wr_data = 8'h5A; repeat (3) cyc();
    dev_cmd_ack = 4'b0100; cyc();
    dev_cmd_ack = '0; cyc();
    cpu_wr_valid = 0; cyc();
    // all channels requesting, consumer always ready
    dev_rd_data = 32'h44332211; dev_rd_valid = 4'hF; bus_out_ready = 1;
    repeat (11) cyc();
    dev_rd_valid = '0; cyc(); cyc();
    // clock-enable divider D=3 on ch1, then D=0 on ch0
    cfg_wr = 1; cfg_sel = 1; cfg_div = 4'd3; cyc();
    cfg_wr = 0; repeat (12) cyc();
    cfg_wr = 1; cfg_sel = 0; cfg_div = 4'd0; cyc();
    cfg_wr = 0; repeat (4) cyc();
    // device reset on ch3 with a pending command and a read request
    cpu_wr_valid = 1; cpu_wr_sel = 3; cpu_wr_data = 8'h3C; cyc();
    cpu_wr_valid = 0; cyc();
    dev_rd_valid = 4'b1000; dev_rd_data = 32'hC3000000; cfg_rst = 1; cfg_sel = 3; cyc();
    cfg_rst = 0; repeat (4) cyc();
    dev_rd_valid = '0; repeat (3) cyc();
    // simultaneous write and reset on the same channel: reset wins
    cpu_wr_valid = 1; cpu_wr_sel = 1; cpu_wr_data = 8'h77; cfg_rst = 1; cfg_sel = 1; cyc();
    cpu_wr_valid = 0; cfg_rst = 0; repeat (6) cyc();
`ifdef VMBA_TIMEOUT_EN
    cpu_wr_valid = 1; cpu_wr_sel = 0; cpu_wr_data = 8'h11; cyc();
    cpu_wr_valid = 0; repeat (12) cyc();
    cfg_rst = 1; cfg_sel = 0; cyc();
    cfg_rst = 0; repeat (6) cyc();
`endif
    // randomised traffic including occasional async reset
    for (int n = 0; n < 1500; n++) begin
      rst           = ($urandom_range(0, 99) != 0);
      cpu_wr_valid  = $urandom_range(0, 1) == 1;
      cpu_wr_sel    = SELW'($urandom);
      cpu_wr_data   = DW'($urandom);
      cfg_wr        = $urandom_range(0, 19) == 0;
      cfg_rst       = $urandom_range(0, 29) == 0;
      cfg_sel       = SELW'($urandom);
      cfg_div       = DIVW'($urandom);
      dev_cmd_ack   = NCH'($urandom);
      dev_rd_valid  = NCH'($urandom);
      dev_rd_data   = $urandom;
      bus_out_ready = $urandom_range(0, 4) < 3;
      cyc();
    end
    rst = 1'b1;
    idle_inputs();
    repeat (8) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
